// File: rtl/fetch_queue.sv
// fetch_queue: decoupling FIFO between fetch and decode.
// Circular buffer of DEPTH fetch_data_t entries with wrap-bit pointers,
// valid/ready on both sides, flushed on frontend redirect.
// Optional macro FETCH_QUEUE_BYPASS_EN: when the queue is empty, an incoming
// packet is presented to decode in the same cycle (0-cycle latency).

package fetch_queue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic [7:0]  bp;
    } fetch_data_t;
endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush_i,
    input  fetch_data_t      in_i,
    input  logic             in_i_valid,
    output logic             in_i_ready,
    output fetch_data_t      out_o,
    output logic             out_o_valid,
    input  logic             out_o_ready,
    output logic [CNT_W-1:0] count_o
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [CNT_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] rptr_q, rptr_d;
    fetch_data_t      mem_q [DEPTH];

    logic empty_s;
    logic full_s;
    logic store_valid_s;
    logic push_s;
    logic pop_s;

    assign empty_s = (wptr_q == rptr_q);
    assign full_s  = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) &&
                     (wptr_q[CNT_W-1] != rptr_q[CNT_W-1]);
    assign count_o = wptr_q - rptr_q;

    // Handshake and output selection; flush and reset mask both sides.
    always_comb begin
        in_i_ready    = 1'b0;
        store_valid_s = 1'b0;
        out_o_valid   = 1'b0;
        out_o         = mem_q[rptr_q[IDX_W-1:0]];
        push_s        = 1'b0;
        pop_s         = 1'b0;

        in_i_ready    = !full_s && !flush_i && rstn;
        store_valid_s = !empty_s && !flush_i && rstn;
        pop_s         = store_valid_s && out_o_ready;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (empty_s && !flush_i && rstn) begin
            // Empty queue: present the incoming packet directly; only store it
            // if decode does not take it this cycle.
            out_o_valid = in_i_valid;
            out_o       = in_i;
            push_s      = in_i_valid && in_i_ready && !out_o_ready;
        end else begin
            out_o_valid = store_valid_s;
            push_s      = in_i_valid && in_i_ready;
        end
`else
        out_o_valid = store_valid_s;
        push_s      = in_i_valid && in_i_ready;
`endif
    end

    // Pointer next-state: flush clears both pointers, otherwise advance on handshakes.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            wptr_d = wptr_q + CNT_W'(push_s);
            rptr_d = rptr_q + CNT_W'(pop_s);
        end
    end

    // Pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Entry storage; deliberately not reset, pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q[IDX_W-1:0]] <= in_i;
        end
    end

    fetch_queue_sva #(.DEPTH(DEPTH)) u_sva (
        .clk           (clk),
        .rstn          (rstn),
        .push_i        (push_s),
        .pop_i         (pop_s),
        .full_i        (full_s),
        .empty_i       (empty_s),
        .store_valid_i (store_valid_s),
        .count_i       (count_o)
    );

endmodule

// fetch_queue_sva: protocol/occupancy properties for fetch_queue.
module fetch_queue_sva #(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input logic             clk,
    input logic             rstn,
    input logic             push_i,
    input logic             pop_i,
    input logic             full_i,
    input logic             empty_i,
    input logic             store_valid_i,
    input logic [CNT_W-1:0] count_i
);

    a_no_push_full: assert property (@(posedge clk) disable iff (!rstn) push_i |-> !full_i);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rstn) pop_i |-> !empty_i);
    a_count_range:  assert property (@(posedge clk) disable iff (!rstn) count_i <= CNT_W'(DEPTH));
    a_valid_nempty: assert property (@(posedge clk) disable iff (!rstn) store_valid_i |-> !empty_i);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: scoreboard of accepted packets plus
// an occupancy model; per-scenario tasks check ready/valid/count inline.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             rstn;
    logic             flush_i;
    fetch_data_t      in_i;
    logic             in_i_valid;
    logic             in_i_ready;
    fetch_data_t      out_o;
    logic             out_o_valid;
    logic             out_o_ready;
    logic [CNT_W-1:0] count_o;

    int checks = 0;
    int errors = 0;

    fetch_data_t sb[$];
    int  m_cnt  = 0;
    bit  m_push = 1'b0;
    bit  m_pop  = 1'b0;
    bit  m_clr  = 1'b0;
    bit  m_acc  = 1'b0;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush_i     (flush_i),
        .in_i        (in_i),
        .in_i_valid  (in_i_valid),
        .in_i_ready  (in_i_ready),
        .out_o       (out_o),
        .out_o_valid (out_o_valid),
        .out_o_ready (out_o_ready),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic fetch_data_t mk(input logic [31:0] pc);
        fetch_data_t p;
        p.pc   = pc;
        p.data = pc ^ 32'hA5A5_0F0F;
        p.bp   = pc[9:2] ^ 8'h3C;
        return p;
    endfunction

    // Scoreboard: every packet handed to decode must be the oldest accepted one.
    always @(negedge clk) begin
        if (out_o_valid && out_o_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got pc=%h, expected no packet", out_o.pc);
            end else begin
                fetch_data_t e;
                e = sb.pop_front();
                if (out_o !== e) begin
                    errors++;
                    $display("FAIL sb_data: got pc=%h data=%h bp=%h, expected pc=%h data=%h bp=%h",
                             out_o.pc, out_o.data, out_o.bp, e.pc, e.data, e.bp);
                end
            end
        end
    end

    // Apply inputs for one cycle and predict its effect from the model.
    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy,
                         input logic fl, input logic rn);
        bit byp;
        in_i_valid  = v;
        in_i        = mk(pc);
        out_o_ready = rdy;
        flush_i     = fl;
        rstn        = rn;
        m_clr  = !rn || fl;
        m_pop  = rn && !fl && (m_cnt > 0) && rdy;
        byp    = BYP && rn && !fl && (m_cnt == 0) && v && rdy;
        m_acc  = v && rn && !fl && (m_cnt < DEPTH);
        m_push = m_acc && !byp;
        if (m_clr) sb.delete();
        else if (m_acc) sb.push_back(mk(pc));
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_clr) m_cnt = 0;
        else m_cnt = m_cnt + int'(m_push) - int'(m_pop);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (in_i_ready !== 1'b0 || out_o_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_active: got ready=%b valid=%b, expected 0 0", in_i_ready, out_o_valid);
        end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (count_o !== 3'd0 || in_i_ready !== 1'b1 || out_o_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: got count=%0d ready=%b valid=%b, expected 0 1 0",
                     count_o, in_i_ready, out_o_valid);
        end
        tick();
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h100 + 32'(4 * k), 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            checks++;
            if (in_i_ready !== 1'b1 || count_o !== 3'(k)) begin
                errors++;
                $display("FAIL fill_push%0d: got ready=%b count=%0d, expected 1 %0d",
                         k, in_i_ready, count_o, k);
            end
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (count_o !== 3'd4 || in_i_ready !== 1'b0 || out_o_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: got count=%0d ready=%b valid=%b, expected 4 0 1",
                     count_o, in_i_ready, out_o_valid);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
            @(negedge clk);
            checks++;
            if (out_o_valid !== 1'b1 || out_o.pc !== 32'h100 + 32'(4 * k)) begin
                errors++;
                $display("FAIL fill_drain%0d: got valid=%b pc=%h, expected 1 %h",
                         k, out_o_valid, out_o.pc, 32'h100 + 32'(4 * k));
            end
            tick();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (out_o_valid !== 1'b0 || count_o !== 3'd0) begin
            errors++;
            $display("FAIL fill_empty: got valid=%b count=%0d, expected 0 0", out_o_valid, count_o);
        end
        tick();
    endtask

    task automatic test_full_push_pop();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h500 + 32'(4 * k), 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(1'b1, 32'h510, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (in_i_ready !== 1'b0 || out_o_valid !== 1'b1 || count_o !== 3'd4) begin
            errors++;
            $display("FAIL full_pp_first: got ready=%b valid=%b count=%0d, expected 0 1 4",
                     in_i_ready, out_o_valid, count_o);
        end
        tick();
        drive(1'b1, 32'h510, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (in_i_ready !== 1'b1 || count_o !== 3'd3) begin
            errors++;
            $display("FAIL full_pp_second: got ready=%b count=%0d, expected 1 3", in_i_ready, count_o);
        end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (count_o !== 3'd3) begin
            errors++;
            $display("FAIL full_pp_count: got count=%0d, expected 3", count_o);
        end
        tick();
        for (int c = 0; c < 8 && m_cnt > 0; c++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
            tick();
        end
        checks++;
        if (sb.size() != 0 || count_o !== 3'd0) begin
            errors++;
            $display("FAIL full_pp_drain: got left=%0d count=%0d, expected 0 0", sb.size(), count_o);
        end
    endtask

    task automatic test_wrap();
        int i = 0;
        for (int c = 0; c < 60 && i < 10; c++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), (c % 2 == 0), 1'b0, 1'b1);
            if (m_acc) i++;
            tick();
        end
        for (int c = 0; c < 10 && m_cnt > 0; c++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (i != 10 || sb.size() != 0 || count_o !== 3'd0 || out_o_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: got sent=%0d left=%0d count=%0d valid=%b, expected 10 0 0 0",
                     i, sb.size(), count_o, out_o_valid);
        end
        tick();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h600 + 32'(4 * k), 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(1'b1, 32'h60C, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (in_i_ready !== 1'b0 || out_o_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: got ready=%b valid=%b, expected 0 0", in_i_ready, out_o_valid);
        end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (count_o !== 3'd0 || out_o_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: got count=%0d valid=%b, expected 0 0", count_o, out_o_valid);
        end
        tick();
        drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (out_o_valid !== 1'b1 || out_o.pc !== 32'h300) begin
            errors++;
            $display("FAIL flush_next: got valid=%b pc=%h, expected 1 300", out_o_valid, out_o.pc);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h700 + 32'(4 * k), 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(1'b1, 32'h708, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (in_i_ready !== 1'b0 || out_o_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_active: got ready=%b valid=%b, expected 0 0", in_i_ready, out_o_valid);
        end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (count_o !== 3'd0 || out_o_valid !== 1'b0 || in_i_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_release: got count=%0d valid=%b ready=%b, expected 0 0 1",
                     count_o, out_o_valid, in_i_ready);
        end
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
            tick();
        end
    endtask

    task automatic test_bypass();
        logic exp_v;
        exp_v = BYP;
        drive(1'b1, 32'h400, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (out_o_valid !== exp_v || count_o !== 3'd0) begin
            errors++;
            $display("FAIL bypass_same: got valid=%b count=%0d, expected %b 0", out_o_valid, count_o, exp_v);
        end
        checks++;
        if (exp_v && out_o.pc !== 32'h400) begin
            errors++;
            $display("FAIL bypass_pc: got pc=%h, expected 400", out_o.pc);
        end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (out_o_valid !== !exp_v || (!exp_v && out_o.pc !== 32'h400)) begin
            errors++;
            $display("FAIL bypass_next: got valid=%b pc=%h, expected valid=%b pc=400",
                     out_o_valid, out_o.pc, !exp_v);
        end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (count_o !== 3'd0 || sb.size() != 0) begin
            errors++;
            $display("FAIL bypass_end: got count=%0d left=%0d, expected 0 0", count_o, sb.size());
        end
        tick();
    endtask

    initial begin
        rstn = 1'b0; flush_i = 1'b0; in_i_valid = 1'b0; out_o_ready = 1'b0; in_i = mk(32'h0);
        test_reset();
        test_fill();
        test_full_push_pop();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling FIFO between the fetch unit and the decode stage.
- Buffers fetch_data_t packets (pc, raw instruction data, branch prediction bp) so fetch can keep running while decode back-pressures.
- Drives decode's instruction input through a valid/ready handshake.
- Flushed on redirect, so wrong-path instructions never reach decode.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2 and at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter. Derived; not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  reset; synchronous, active-low.
- flush_i  input  1  discard all entries (frontend redirect).
- in_i  input  fetch_data_t  packet from fetch.
- in_i_valid  input  1  in_i holds a valid packet.
- in_i_ready  output  1  queue accepts a push this cycle.
- out_o  output  fetch_data_t  oldest packet, to decode.
- out_o_valid  output  1  out_o is valid.
- out_o_ready  input  1  decode consumes out_o this cycle.
- count_o  output  CNT_W  current occupancy (0..DEPTH).

Behaviour:
- Storage: circular array of DEPTH fetch_data_t entries.
  - Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty = pointers equal. full = index bits equal and wrap bits differ.
  - Storage array is not reset. Only pointers are reset.
- Push: in_i_valid && in_i_ready.
  - Write in_i at wptr; wptr+1 at the clock edge.
- Pop: out_o_valid && out_o_ready.
  - rptr+1 at the clock edge.
- in_i_ready = !full && !flush_i && rstn.
  - Does not depend on out_o_ready: no push into a full queue, even if a pop happens the same cycle.
- out_o_valid = !empty && !flush_i.
- out_o = entry at rptr. It is driven from registered storage, so push-to-pop latency is 1 cycle minimum.
- count_o = wptr - rptr (modular, CNT_W bits). It reflects the state before this cycle's push/pop.
- Simultaneous push and pop (queue neither empty nor full): both pointers advance; count unchanged.
- Wrap-around: pointers roll from index DEPTH-1 to 0 and toggle the wrap bit. FIFO order is preserved across the wrap.
- Flush (flush_i=1):
  - in_i_ready=0 and out_o_valid=0 in that cycle, so no push or pop is accepted.
  - At the edge, wptr=rptr=0.
  - The queue is empty from the next cycle. count_o=0 next cycle.
- Reset (rstn=0 at an edge): wptr=rptr=0, regardless of any in-flight handshake.
  - While rstn=0: in_i_ready=0, out_o_valid=0.
  - First cycle after release: count_o=0, in_i_ready=1, out_o_valid=0.
- Priority: rstn over flush_i over push/pop.
- Assertions:
  - Never push when full.
  - Never pop when empty.
  - count_o <= DEPTH.
  - out_o_valid |-> !empty.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when the queue is empty and flush_i=0 and rstn=1:
  - out_o_valid = in_i_valid and out_o = in_i (combinational, 0-cycle latency).
  - If out_o_ready=1 that cycle, the packet is consumed directly. Pointers do not move and nothing is written.
  - If out_o_ready=0, the packet is pushed normally.
  - count_o is unaffected by a bypassed packet.
- Not defined: out_o is always driven from storage; minimum latency is 1 cycle; no combinational path from in_i to out_o.

Test Plan:
- Fill, DEPTH=4, out_o_ready=0:
  - Push pc 0x100, 0x104, 0x108, 0x10C.
  - count_o=4; in_i_ready=0 after the 4th push.
  - Drain: out_o.pc = 0x100, 0x104, 0x108, 0x10C in order; then out_o_valid=0, count_o=0.
- Full plus simultaneous push/pop:
  - Queue full; assert in_i_valid and out_o_ready.
  - Only the pop occurs (in_i_ready=0); count_o goes 4 to 3.
  - Next cycle push and pop are both accepted; count_o stays 3.
- Wrap-around:
  - Stream 10 packets pc 0x200+4*i with out_o_ready toggling 1,0,1,0.
  - All 10 emerge in order with bp fields intact; no loss or duplication.
- Flush:
  - Queue holds 3 entries; flush_i=1 with in_i_valid=1 in the same cycle.
  - That cycle: in_i_ready=0 and out_o_valid=0.
  - Next cycle: count_o=0, out_o_valid=0.
  - A subsequent push of pc 0x300 emerges as the next out_o.
- Reset mid-operation:
  - Queue holds 2 entries; drive rstn=0 for 1 cycle.
  - After release: count_o=0, out_o_valid=0, in_i_ready=1; old entries never appear.
- Bypass, with FETCH_QUEUE_BYPASS_EN:
  - Empty queue; in_i_valid=1, pc 0x400, out_o_ready=1.
  - Same cycle: out_o_valid=1, out_o.pc=0x400; count_o stays 0.
- Bypass macro absent: same stimulus gives out_o_valid=0 that cycle and pc 0x400 one cycle later.
